// File: rtl/fir_tf_param.sv
// Parametrised transposed-form FIR filter with a sample-valid handshake.
// Two pipeline stages: the products are registered first, then they are
// folded into the partial-sum chain. Coefficients are double-buffered and
// swap atomically. The output is rounded and saturated, and a sticky flag
// records any clamp.
module fir_tf_param #(
    parameter int TAPS  = 4,
    parameter int DW    = 17,
    parameter int CW    = 17,
    parameter int OW    = 36,
    parameter int SHIFT = 0,
    parameter int ROUND = 1,
    localparam int AIW  = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic signed [DW-1:0] x_in,
    input  logic                 clear,
    input  logic                 coef_wr,
    input  logic [AIW-1:0]       coef_addr,
    input  logic signed [CW-1:0] coef_data,
    input  logic                 coef_swap,
    output logic signed [OW-1:0] y_out,
    output logic                 out_valid,
    output logic                 sat_flag
);

    localparam int PW = DW + CW;
    localparam int AW = PW + AIW;

    // Half an output LSB, added before the shift when rounding is enabled.
    localparam logic [AW:0] RND_INC =
        (ROUND != 0 && SHIFT > 0) ? ((AW+1)'(1) << ((SHIFT > 0) ? SHIFT - 1 : 0)) : '0;

    logic signed [CW-1:0] r_shadow [TAPS];
    logic signed [CW-1:0] r_active [TAPS];
    logic signed [PW-1:0] r_p      [TAPS];
    logic signed [AW-1:0] r_s      [1:TAPS-1];
    logic                 r_v1;
    logic signed [OW-1:0] r_y;
    logic                 r_ov;
    logic                 r_sat;

    logic signed [PW-1:0] w_prod   [TAPS];
    logic signed [AW-1:0] w_s_next [1:TAPS-1];
    logic signed [AW-1:0] w_acc;
    logic signed [AW:0]   w_round;
    logic signed [AW:0]   w_shift;
    logic signed [OW-1:0] w_sat_y;
    logic                 w_ovf;

    genvar gi;

    // Full-precision product of the incoming sample with each active coefficient.
    for (gi = 0; gi < TAPS; gi++) begin : g_tap
        assign w_prod[gi] = PW'(x_in) * PW'(r_active[gi]);
    end

    // Next value of the partial-sum chain: each tap adds its product to the
    // downstream sum; the last tap starts the chain.
    for (gi = 1; gi < TAPS; gi++) begin : g_sum
        if (gi == TAPS - 1) begin : g_last
            assign w_s_next[gi] = AW'(r_p[gi]);
        end else begin : g_mid
            assign w_s_next[gi] = AW'(r_p[gi]) + r_s[gi+1];
        end
    end

    assign w_acc   = AW'(r_p[0]) + r_s[1];
    // One bit of headroom so the rounding increment can never wrap.
    assign w_round = {w_acc[AW-1], w_acc} + $signed(RND_INC);
    assign w_shift = w_round >>> SHIFT;

    if (OW >= AW + 1) begin : g_nosat
        // The output is wide enough for any shifted value: sign-extend only.
        assign w_sat_y = OW'(w_shift);
        assign w_ovf   = 1'b0;
    end else begin : g_sat
        localparam logic signed [OW-1:0] Y_MAX = {1'b0, {(OW-1){1'b1}}};
        localparam logic signed [OW-1:0] Y_MIN = {1'b1, {(OW-1){1'b0}}};
        logic [AW-OW+1:0] w_top;
        // The value fits only if every bit above the output sign bit repeats it.
        assign w_top   = w_shift[AW:OW-1];
        assign w_ovf   = !((&w_top) || !(|w_top));
        assign w_sat_y = w_ovf ? (w_shift[AW] ? Y_MIN : Y_MAX) : w_shift[OW-1:0];
    end

    // Coefficient banks: the swap copies the pre-write shadow, and a write
    // lands in shadow only. Clear leaves both banks alone.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < TAPS; k++) begin
                r_shadow[k] <= '0;
                r_active[k] <= '0;
            end
        end else begin
            if (coef_swap) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_active[k] <= r_shadow[k];
                end
            end
            if (coef_wr && (int'(coef_addr) < TAPS)) begin
                r_shadow[coef_addr] <= coef_data;
            end
        end
    end

    // Stage 1: capture the products of each accepted sample; v1 marks them fresh.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_v1 <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_p[k] <= '0;
            end
        end else if (clear) begin
            r_v1 <= 1'b0;
            for (int k = 0; k < TAPS; k++) begin
                r_p[k] <= '0;
            end
        end else begin
            r_v1 <= in_valid;
            if (in_valid) begin
                for (int k = 0; k < TAPS; k++) begin
                    r_p[k] <= w_prod[k];
                end
            end
        end
    end

    // Stage 2: advance the sum chain and register the output only on fresh
    // products, so idle cycles never push bubbles into the filter state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_y   <= '0;
            r_ov  <= 1'b0;
            r_sat <= 1'b0;
            for (int k = 1; k < TAPS; k++) begin
                r_s[k] <= '0;
            end
        end else if (clear) begin
            r_y   <= '0;
            r_ov  <= 1'b0;
            r_sat <= 1'b0;
            for (int k = 1; k < TAPS; k++) begin
                r_s[k] <= '0;
            end
        end else begin
            r_ov <= r_v1;
            if (r_v1) begin
                for (int k = 1; k < TAPS; k++) begin
                    r_s[k] <= w_s_next[k];
                end
                r_y <= w_sat_y;
                if (w_ovf) begin
                    r_sat <= 1'b1;
                end
            end
        end
    end

    assign y_out     = r_y;
    assign out_valid = r_ov;
    assign sat_flag  = r_sat;

endmodule

// File: tb/tb_fir_tf_param.sv
// Self-checking bench for fir_tf_param. Four instances with different output
// settings share one stimulus stream. A sample-history reference model
// predicts every output on every clock.
module tb_fir_tf_param;

    localparam int TAPS = 4;
    localparam int NI   = 4;

    logic               clk;
    logic               reset;
    logic               in_valid;
    logic signed [16:0] x_in;
    logic               clear;
    logic               coef_wr;
    logic [1:0]         coef_addr;
    logic signed [16:0] coef_data;
    logic               coef_swap;

    logic signed [35:0] y0, y2, y3;
    logic signed [15:0] y1;
    logic               ov0, ov1, ov2, ov3;
    logic               sat0, sat1, sat2, sat3;

    int ow_tab  [NI] = '{36, 16, 36, 36};
    int sh_tab  [NI] = '{0, 0, 2, 2};
    int rnd_tab [NI] = '{1, 1, 1, 0};

    fir_tf_param u_def (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in), .clear(clear),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
        .y_out(y0), .out_valid(ov0), .sat_flag(sat0));

    fir_tf_param #(.OW(16)) u_sat (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in), .clear(clear),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
        .y_out(y1), .out_valid(ov1), .sat_flag(sat1));

    fir_tf_param #(.SHIFT(2), .ROUND(1)) u_rnd (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in), .clear(clear),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
        .y_out(y2), .out_valid(ov2), .sat_flag(sat2));

    fir_tf_param #(.SHIFT(2), .ROUND(0)) u_trn (
        .clk(clk), .reset(reset), .in_valid(in_valid), .x_in(x_in), .clear(clear),
        .coef_wr(coef_wr), .coef_addr(coef_addr), .coef_data(coef_data), .coef_swap(coef_swap),
        .y_out(y3), .out_valid(ov3), .sat_flag(sat3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state
    longint m_sh   [TAPS];
    longint m_act  [TAPS];
    longint m_hist [TAPS][TAPS];   // m_hist[j] = products of the j-th most recent sample
    longint m_pend [TAPS];
    bit     m_pend_v;
    longint m_y    [NI];
    bit     m_sat  [NI];
    bit     m_ov;

    longint cur_x;
    longint cur_data;
    int     cur_addr;

    task automatic check_value(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    endtask

    function automatic void post_proc(input longint acc, input int ow, input int sh, input int rnd,
                                      output longint y, output bit ovf);
        longint v;
        longint vmax;
        longint vmin;
        v = acc;
        if (rnd != 0 && sh > 0) v = v + (longint'(1) << (sh - 1));
        v = v >>> sh;
        vmax = (longint'(1) << (ow - 1)) - 1;
        vmin = -(longint'(1) << (ow - 1));
        y = v;
        ovf = 1'b0;
        if (v > vmax) begin y = vmax; ovf = 1'b1; end
        else if (v < vmin) begin y = vmin; ovf = 1'b1; end
    endfunction

    task automatic model_reset();
        for (int k = 0; k < TAPS; k++) begin
            m_sh[k] = 0; m_act[k] = 0; m_pend[k] = 0;
            for (int j = 0; j < TAPS; j++) m_hist[j][k] = 0;
        end
        m_pend_v = 1'b0;
        m_ov = 1'b0;
        for (int i = 0; i < NI; i++) begin m_y[i] = 0; m_sat[i] = 1'b0; end
    endtask

    // One rising edge: y[n] = sum_k c_(n-k)[k] * x[n-k], where each sample
    // carries the bank that was active when it was accepted.
    task automatic model_edge();
        longint acc;
        longint yy;
        bit     o;
        m_ov = 1'b0;
        if (clear) begin
            for (int j = 0; j < TAPS; j++)
                for (int k = 0; k < TAPS; k++) m_hist[j][k] = 0;
            m_pend_v = 1'b0;
            for (int i = 0; i < NI; i++) begin m_y[i] = 0; m_sat[i] = 1'b0; end
        end else begin
            if (m_pend_v) begin
                for (int j = TAPS - 1; j > 0; j--)
                    for (int k = 0; k < TAPS; k++) m_hist[j][k] = m_hist[j-1][k];
                for (int k = 0; k < TAPS; k++) m_hist[0][k] = m_pend[k];
                acc = 0;
                for (int k = 0; k < TAPS; k++) acc += m_hist[k][k];
                for (int i = 0; i < NI; i++) begin
                    post_proc(acc, ow_tab[i], sh_tab[i], rnd_tab[i], yy, o);
                    m_y[i] = yy;
                    if (o) m_sat[i] = 1'b1;
                end
                m_ov = 1'b1;
            end
            m_pend_v = in_valid;
            if (in_valid)
                for (int k = 0; k < TAPS; k++) m_pend[k] = cur_x * m_act[k];
        end
        if (coef_swap)
            for (int k = 0; k < TAPS; k++) m_act[k] = m_sh[k];
        if (coef_wr && cur_addr < TAPS) m_sh[cur_addr] = cur_data;
    endtask

    task automatic check_all();
        longint yv  [NI];
        bit     ovv [NI];
        bit     sv  [NI];
        yv[0] = y0; yv[1] = y1; yv[2] = y2; yv[3] = y3;
        ovv[0] = ov0; ovv[1] = ov1; ovv[2] = ov2; ovv[3] = ov3;
        sv[0] = sat0; sv[1] = sat1; sv[2] = sat2; sv[3] = sat3;
        for (int i = 0; i < NI; i++) begin
            check_value($sformatf("out_valid[%0d]", i), longint'(ovv[i]), longint'(m_ov));
            check_value($sformatf("y_out[%0d]", i), yv[i], m_y[i]);
            check_value($sformatf("sat_flag[%0d]", i), longint'(sv[i]), longint'(m_sat[i]));
        end
    endtask

    task automatic edge_check();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic step(input bit iv, input longint x, input bit clr, input bit wr,
                        input int addr, input longint data, input bit sw);
        @(negedge clk);
        in_valid  = iv;
        cur_x     = x;
        x_in      = x[16:0];
        clear     = clr;
        coef_wr   = wr;
        cur_addr  = addr;
        coef_addr = addr[1:0];
        cur_data  = data;
        coef_data = data[16:0];
        coef_swap = sw;
        edge_check();
    endtask

    task automatic send(input longint x);
        step(1'b1, x, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic do_clear();
        step(1'b0, 0, 1'b1, 1'b0, 0, 0, 1'b0);
    endtask

    task automatic write_shadow(input longint c0, input longint c1, input longint c2, input longint c3);
        step(1'b0, 0, 1'b0, 1'b1, 0, c0, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 1, c1, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 2, c2, 1'b0);
        step(1'b0, 0, 1'b0, 1'b1, 3, c3, 1'b0);
    endtask

    task automatic load_bank(input longint c0, input longint c1, input longint c2, input longint c3);
        write_shadow(c0, c1, c2, c3);
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
    endtask

    function automatic longint rand17();
        return longint'($urandom_range(0, 131071)) - 65536;
    endfunction

    initial begin
        reset = 1'b0; in_valid = 1'b0; x_in = '0; clear = 1'b0;
        coef_wr = 1'b0; coef_addr = '0; coef_data = '0; coef_swap = 1'b0;
        cur_x = 0; cur_data = 0; cur_addr = 0;
        model_reset();
        #1;
        check_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;

        // Impulse, consecutive samples
        load_bank(1, 2, 3, 4);
        do_clear();
        send(1); send(0); send(0); send(0); send(0);
        idle(3);

        // Same impulse with three idle cycles between samples
        do_clear();
        send(1); idle(3); send(0); idle(3); send(0); idle(3); send(0); idle(3);

        // Swap on the edge of the fifth sample
        load_bank(1, 1, 1, 1);
        do_clear();
        write_shadow(2, 2, 2, 2);
        send(1); send(1); send(1); send(1);
        step(1'b1, 1, 1'b0, 1'b0, 0, 0, 1'b1);
        send(1); send(1); send(1); send(1); send(1);
        idle(2);

        // Write together with swap: active takes the pre-write shadow
        step(1'b0, 0, 1'b0, 1'b1, 0, 9, 1'b1);
        do_clear();
        send(1); idle(2);
        step(1'b0, 0, 1'b0, 1'b0, 0, 0, 1'b1);
        send(1); idle(2);

        // Saturation, clear, then negative full scale
        load_bank(65535, 65535, 65535, 65535);
        do_clear();
        send(65535); send(65535); send(65535); send(65535);
        idle(2);
        do_clear();
        send(1); send(0); send(0); send(0); send(0);
        idle(2);
        do_clear();
        send(-65536); send(-65536); idle(2);

        // Rounding / truncation
        load_bank(3, 0, 0, 0);
        do_clear();
        send(1); idle(2);
        send(-1); idle(2);
        send(5); send(-6); send(7); idle(2);

        // Clear on the edge where products would enter the chain
        send(100); do_clear(); idle(2);

        // Randomised traffic
        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 3) != 0), rand17(), ($urandom_range(0, 39) == 0),
                 ($urandom_range(0, 3) == 0), int'($urandom_range(0, 3)), rand17(),
                 ($urandom_range(0, 14) == 0));
        end
        idle(2);

        // Asynchronous reset between acceptance and output
        send(1234);
        #2;
        reset = 1'b0;
        in_valid = 1'b0; clear = 1'b0; coef_wr = 1'b0; coef_swap = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        reset = 1'b1;
        edge_check();
        send(5); idle(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
